// File: rtl/tv80_pkg.sv
// tv80_pkg: shared types and constants for the 16-bit ALU sequencer.
package tv80_pkg;
    typedef enum logic [1:0] {
        OP_ADD16 = 2'b00,
        OP_ADC16 = 2'b01,
        OP_SBC16 = 2'b10,
        OP_INC16 = 2'b11
    } alu16_op_t;
    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_ADC = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_SBC = 4'b0011;
    localparam int FLAG_C = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_P = 2;
    localparam int FLAG_H = 4;
    localparam int FLAG_Z = 6;
    localparam int FLAG_S = 7;
endpackage

// File: rtl/tv80_alu16_seq.sv
// tv80_alu16_seq: two-pass ADD16/ADC16/SBC16 over the shared 8-bit TV80 ALU.
// Defining TV80_ALU16_INC_EN enables op 11 as INC16.
module tv80_alu16_seq
    import tv80_pkg::*;
#(
    parameter int Flag_C = FLAG_C,
    parameter int Flag_N = FLAG_N,
    parameter int Flag_P = FLAG_P,
    parameter int Flag_H = FLAG_H,
    parameter int Flag_Z = FLAG_Z,
    parameter int Flag_S = FLAG_S
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    input  logic [7:0]  f_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] q,
    output logic [7:0]  f_out,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [3:0]  alu_op,
    output logic        alu_arith16,
    output logic        alu_z16,
    output logic [7:0]  alu_busa,
    output logic [7:0]  alu_busb,
    output logic [7:0]  alu_fin,
    input  logic [7:0]  alu_q,
    input  logic [7:0]  alu_fout
);
    state_t      state, state_nx;
    alu16_op_t   op_r;
    logic [15:0] a_r, b_r;
    logic [7:0]  f_r, fl, lo_q, f_res;
    logic        accept, hi, pass;

`ifdef TV80_ALU16_INC_EN
    assign accept = start;
`else
    assign accept = start && op != OP_INC16;
`endif
    assign hi   = state == S_HI;
    assign pass = state == S_LO || hi;
    assign busy = state != S_IDLE;
    assign done = state == S_DONE;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = accept ? S_LO : S_IDLE;
            S_LO:    state_nx = alu_gnt ? S_HI : S_LO;
            S_HI:    state_nx = alu_gnt ? S_DONE : S_HI;
            default: state_nx = S_IDLE;
        endcase
    end

    // Low pass starts from the caller's flags; high pass chains carry and Z through fl.
    always_comb begin
        alu_req     = pass;
        alu_op      = '0;
        alu_arith16 = 1'b0;
        alu_z16     = 1'b0;
        alu_busa    = '0;
        alu_busb    = '0;
        alu_fin     = '0;
        if (pass) begin
            alu_op      = op_r == OP_SBC16 ? ALU_SBC : (op_r == OP_ADC16 || hi) ? ALU_ADC : ALU_ADD;
            alu_arith16 = op_r == OP_ADD16;
            alu_z16     = hi && (op_r == OP_ADC16 || op_r == OP_SBC16);
            alu_busa    = hi ? a_r[15:8] : a_r[7:0];
            alu_busb    = op_r == OP_INC16 ? {7'd0, ~hi} : hi ? b_r[15:8] : b_r[7:0];
            alu_fin     = hi ? fl : f_r;
        end
    end

    always_comb begin
        f_res         = alu_fout;
        f_res[Flag_S] = op_r == OP_ADD16 ? f_r[Flag_S] : alu_fout[Flag_S];
        f_res[Flag_Z] = op_r == OP_ADD16 ? f_r[Flag_Z] : ~|{alu_q, lo_q};
        f_res[Flag_P] = op_r == OP_ADD16 ? f_r[Flag_P] : alu_fout[Flag_P];
        f_res[Flag_H] = alu_fout[Flag_H];
        f_res[Flag_N] = op_r == OP_SBC16;
        f_res[Flag_C] = alu_fout[Flag_C];
`ifdef TV80_ALU16_INC_EN
        if (op_r == OP_INC16) f_res = f_r;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            op_r  <= OP_ADD16;
            a_r   <= '0;
            b_r   <= '0;
            f_r   <= '0;
            fl    <= '0;
            lo_q  <= '0;
            q     <= '0;
            f_out <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && accept) begin
                op_r <= alu16_op_t'(op);
                a_r  <= a_in;
                b_r  <= b_in;
                f_r  <= f_in;
            end
            if (state == S_LO && alu_gnt) begin
                lo_q <= alu_q;
                fl   <= alu_fout;
            end
            if (hi && alu_gnt) begin
                q     <= {alu_q, lo_q};
                f_out <= f_res;
            end
        end
    end
endmodule

// File: tb/tb_tv80_alu16_seq.sv
// tb_tv80_alu16_seq: table vectors, directed corner sequences and random ops
// checked against a 16-bit Z80 arithmetic model; includes an 8-bit TV80 ALU stub.
module tb_tv80_alu16_seq;
    logic        clk = 0, reset = 1, start = 0, alu_gnt = 1;
    logic [1:0]  op_i = 0;
    logic [15:0] a_i = 0, b_i = 0;
    logic [7:0]  f_i = 0;
    logic        busy, done, alu_req, alu_arith16, alu_z16;
    logic [15:0] q;
    logic [7:0]  f_out, alu_busa, alu_busb, alu_fin, alu_q, alu_fout;
    logic [3:0]  alu_op;
    int          checks = 0, errors = 0;

    tv80_alu16_seq dut (
        .clk(clk), .reset(reset), .start(start), .op(op_i), .a_in(a_i), .b_in(b_i), .f_in(f_i),
        .busy(busy), .done(done), .q(q), .f_out(f_out),
        .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_op(alu_op), .alu_arith16(alu_arith16),
        .alu_z16(alu_z16), .alu_busa(alu_busa), .alu_busb(alu_busb), .alu_fin(alu_fin),
        .alu_q(alu_q), .alu_fout(alu_fout)
    );

    always #5 clk = ~clk;

    // TV80 8-bit ALU behaviour for ops ADD/ADC/SUB/SBC
    function automatic logic [15:0] alu8(input logic [3:0] o, input logic [7:0] x, y, fi,
                                         input logic ar16, z16);
        logic       sub, ci;
        logic [8:0] s;
        logic [4:0] h;
        logic [7:0] yb, r, f;
        sub = o[1];
        ci  = sub ^ (o[0] & fi[0]);
        yb  = sub ? ~y : y;
        s   = {1'b0, x} + {1'b0, yb} + {8'd0, ci};
        h   = {1'b0, x[3:0]} + {1'b0, yb[3:0]} + {4'd0, ci};
        r   = s[7:0];
        f   = fi;
        f[0] = sub ^ s[8];
        f[1] = sub;
        f[2] = (x[7] == yb[7]) && (r[7] != x[7]);
        f[3] = r[3];
        f[4] = sub ^ h[4];
        f[5] = r[5];
        f[6] = (r == 8'd0) ? (z16 ? fi[6] : 1'b1) : 1'b0;
        f[7] = r[7];
        if (ar16) begin
            f[7] = fi[7];
            f[6] = fi[6];
            f[2] = fi[2];
        end
        return {r, f};
    endfunction

    always_comb {alu_q, alu_fout} = alu8(alu_op, alu_busa, alu_busb, alu_fin, alu_arith16, alu_z16);

    // Z80 16-bit reference: returns {q, flags}
    function automatic logic [23:0] ref16(input logic [1:0] o, input logic [15:0] a, b,
                                          input logic [7:0] f);
        int          c, full, sr;
        logic [15:0] r;
        logic        hc, v, cy;
        c = (o == 2'd0) ? 0 : int'(f[0]);
        if (o == 2'd3) return {a + 16'd1, f};
        if (o == 2'd2) begin
            full = int'(a) - int'(b) - c;
            sr   = int'($signed(a)) - int'($signed(b)) - c;
            hc   = int'(a & 16'hfff) < int'(b & 16'hfff) + c;
            cy   = full < 0;
        end else begin
            full = int'(a) + int'(b) + c;
            sr   = int'($signed(a)) + int'($signed(b)) + c;
            hc   = int'(a & 16'hfff) + int'(b & 16'hfff) + c > 'hfff;
            cy   = full > 'hffff;
        end
        r = full[15:0];
        v = sr > 32767 || sr < -32768;
        if (o == 2'd0) return {r, f[7], f[6], r[13], hc, r[11], f[2], 1'b0, cy};
        return {r, r[15], r == 16'd0, r[13], hc, r[11], v, o == 2'd2, cy};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Issues one op; grant drops with probability stall_pct while passes remain.
    task automatic run(input logic [1:0] o, input logic [15:0] a, b, input logic [7:0] f,
                       input int stall_pct, output int lat, output int stalls, output bit seen);
        int passes = 0;
        logic g;
        op_i = o; a_i = a; b_i = b; f_i = f;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        lat = 1; stalls = 0; seen = 0;
        while (!seen && lat < 100) begin
            g = passes < 2 ? ($urandom_range(99) >= stall_pct) : 1'b1;
            alu_gnt = g;
            if (passes < 2) begin
                if (g) passes++;
                else stalls++;
            end
            @(posedge clk); #1;
            lat++;
            if (done) seen = 1;
        end
        alu_gnt = 1;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a, b;
        logic [7:0]  f;
        logic [15:0] q;
        logic [7:0]  fo;
    } vec_t;

    initial begin
        vec_t        vt[3];
        int          lat, stalls, dn, first;
        bit          seen;
        logic [23:0] e;
        logic [1:0]  o;
        vt[0] = '{2'b00, 16'h1234, 16'h0FFF, 8'hFF, 16'h2233, 8'hF4};
        vt[1] = '{2'b10, 16'h0001, 16'h0001, 8'h00, 16'h0000, 8'h42};
        vt[2] = '{2'b01, 16'h7FFF, 16'h0000, 8'h01, 16'h8000, 8'h94};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", {busy, done, alu_req}, 0);
        chk("reset_q_f", {q, f_out}, 0);
        chk("reset_alu", {alu_op, alu_arith16, alu_z16, alu_busa, alu_busb, alu_fin}, 0);
        reset = 0;

        for (int i = 0; i < 3; i++) begin
            run(vt[i].op, vt[i].a, vt[i].b, vt[i].f, 0, lat, stalls, seen);
            chk("vec_done", seen, 1);
            chk("vec_lat", lat, 3);
            chk("vec_q", q, vt[i].q);
            chk("vec_f", f_out, vt[i].fo);
            @(posedge clk); #1;
            chk("vec_idle", {busy, done}, 0);
        end

        // ADD16 with three ungranted LO cycles and a stray start while busy
        op_i = 0; a_i = 16'h1234; b_i = 16'h0FFF; f_i = 8'hFF;
        start = 1; alu_gnt = 0;
        @(posedge clk); #1;
        start = 0;
        chk("stall_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_req", alu_req, 1);
            chk("stall_busa", alu_busa, 8'h34);
            chk("stall_busb", alu_busb, 8'hFF);
            chk("stall_op", alu_op, 4'b0000);
            if (i == 1) begin
                start = 1; op_i = 2; a_i = 16'h5555;
            end
            @(posedge clk); #1;
            start = 0;
        end
        alu_gnt = 1;
        dn = 0; first = -1;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk); #1;
            if (done) begin
                dn++;
                if (first < 0) first = j;
            end
        end
        chk("stall_done_cnt", dn, 1);
        chk("stall_done_at", first, 1);
        chk("stall_q", q, 16'h2233);
        chk("stall_f", f_out, 8'hF4);

        // reset during the high pass
        op_i = 1; a_i = 16'h8181; b_i = 16'h4242; f_i = 8'h00;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        @(posedge clk); #1;
        chk("hi_busa", alu_busa, 8'h81);
        chk("hi_z16", alu_z16, 1);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("rst_hi_busy", busy, 0);
        chk("rst_hi_q_f", {q, f_out}, 0);
        chk("rst_hi_req", alu_req, 0);
        dn = 0;
        repeat (5) begin
            @(posedge clk); #1;
            dn += int'(done) + int'(busy);
        end
        chk("rst_hi_quiet", dn, 0);

        // INC16
`ifdef TV80_ALU16_INC_EN
        op_i = 3; a_i = 16'hFFFF; b_i = 16'h1234; f_i = 8'hA5;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        chk("inc_lo_busb", alu_busb, 8'h01);
        @(posedge clk); #1;
        chk("inc_hi_busb", alu_busb, 8'h00);
        @(posedge clk); #1;
        chk("inc_done", done, 1);
        chk("inc_q", q, 16'h0000);
        chk("inc_f", f_out, 8'hA5);
        @(posedge clk); #1;
`else
        op_i = 3; a_i = 16'hFFFF; f_i = 8'hA5;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        dn = 0;
        repeat (5) begin
            dn += int'(busy) + int'(done) + int'(alu_req);
            @(posedge clk); #1;
        end
        chk("inc_ignored", dn, 0);
`endif

        for (int i = 0; i < 200; i++) begin
`ifdef TV80_ALU16_INC_EN
            o = 2'($urandom_range(3));
`else
            o = 2'($urandom_range(2));
`endif
            a_i = 16'($urandom);
            b_i = 16'($urandom);
            if (i % 8 == 0) b_i = a_i;
            f_i = 8'($urandom);
            e = ref16(o, a_i, b_i, f_i);
            run(o, a_i, b_i, f_i, 30, lat, stalls, seen);
            chk("rnd_done", seen, 1);
            chk("rnd_lat", lat, 3 + stalls);
            chk("rnd_q", q, e[23:8]);
            chk("rnd_f", f_out, e[7:0]);
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tv80_alu16_seq.md
# tv80_alu16_seq

Two-pass sequencer that executes 16-bit arithmetic (ADD16, ADC16, SBC16) on the shared 8-bit TV80 ALU, low byte then high byte. It gates ALU access through a request/grant handshake and chains carry and Z between the passes. It produces one 16-bit result and one flag byte with Z80 semantics. It sits beside the core's ALU mux; the ALU instance lives outside this block.

## Interface

Parameters:
- `Flag_C`, default 0, carry bit index
- `Flag_N`, default 1, subtract bit index
- `Flag_P`, default 2, parity/overflow bit index
- `Flag_H`, default 4, half-carry bit index
- `Flag_Z`, default 6, zero bit index
- `Flag_S`, default 7, sign bit index

Ports:
- `clk`  in  1  clock; single clock domain
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `op`  in  2  00=ADD16, 01=ADC16, 10=SBC16, 11=INC16 (see Configuration)
- `a_in`  in  16  first operand
- `b_in`  in  16  second operand
- `f_in`  in  8  flags at start
- `busy`  out  1  high from the cycle after an accepted start until `done`
- `done`  out  1  one-cycle pulse; `q` and `f_out` are valid
- `q`  out  16  result
- `f_out`  out  8  result flags
- `alu_req`  out  1  ALU access request
- `alu_gnt`  in  1  ALU grant
- `alu_op`  out  4  drives ALU_Op
- `alu_arith16`  out  1  drives Arith16
- `alu_z16`  out  1  drives Z16
- `alu_busa`  out  8  drives BusA
- `alu_busb`  out  8  drives BusB
- `alu_fin`  out  8  drives F_In
- `alu_q`  in  8  ALU Q
- `alu_fout`  in  8  ALU F_Out

## Operation

- FSM states: IDLE, LO, HI, DONE.
- IDLE → LO on `start`. Latch `op`, `a_in`, `b_in` and `f_in`.
- LO → HI on `alu_req && alu_gnt`. Capture `alu_q` into the low result byte and `alu_fout` into the low flag register `fl`.
- HI → DONE on grant. Capture `alu_q` into `q[15:8]`, `q[7:0]` from the low result byte, and `f_out` from `alu_fout`.
- DONE → IDLE unconditionally.
- `alu_req` is high in LO and HI only.
- Per-pass drive:
  - ADD16 LO: op 0000, arith16=1, fin=latched f.
  - ADD16 HI: op 0001, arith16=1, fin=`fl`.
  - ADC16 LO: op 0001, arith16=0, z16=0.
  - ADC16 HI: op 0001, z16=1, fin=`fl`.
  - SBC16: same as ADC16 with op 0011.
- Resulting flags:
  - Z = both bytes zero.
  - S, P/V, H, C come from the high pass.
  - ADD16 preserves S, Z and P/V from `f_in`.
- LO pass drives `a[7:0]`/`b[7:0]`; HI pass drives `a[15:8]`/`b[15:8]`.
- Outside LO/HI, all `alu_*` outputs are 0.
- `start` in any state other than IDLE is ignored; no queueing.
- Reset mid-operation: return to IDLE next edge. No `done`; discard partial results.

## Timing

- Reset values:
  - state IDLE
  - `busy`, `done`, `alu_req` = 0
  - `q` = 0000, `f_out` = 00
  - all `alu_*` outputs = 0
- With `alu_gnt` tied high, `start` at edge 0 → LO in cycle 1, HI in cycle 2, `done` in cycle 3.
- Each cycle `alu_gnt` is low adds one cycle. `alu_*` outputs hold stable while ungranted.
- `q`/`f_out` update only on the HI capture edge and hold until the next completion.

## Configuration

- `TV80_ALU16_INC_EN` defined: op 11 = INC16.
  - LO: op 0000 with `alu_busb` = 01.
  - HI: op 0001 with `alu_busb` = 00.
  - `f_out` = latched `f_in`; no flags are affected.
- Undefined: `start` with op 11 is ignored. The FSM stays in IDLE, with no `busy` and no `done`.

## Structure

- Shared package `tv80_pkg`:
  - op enum `alu16_op_t`
  - ALU_Op constants (ADD, ADC, SUB, SBC, …)
  - flag index constants
  - FSM state enum
- No sub-module. The FSM and datapath are one module; the ALU is instantiated by the parent.

## Test plan

- ADD16, a=1234, b=0FFF, f_in=FF, gnt tied high → `done` at cycle 3, q=2233, f_out=F4.
- SBC16, a=0001, b=0001, f_in=00 → q=0000, f_out=42 (Z=1, N=1, C=0).
- ADC16, a=7FFF, b=0000, f_in=01 → q=8000, f_out=94 (S=1, H=1, V=1, C=0).
- ADD16 with `alu_gnt` low for 3 cycles in LO:
  - `alu_busa`/`alu_op` are held throughout.
  - `done` arrives 3 cycles late.
  - A second `start` while busy is ignored (exactly one `done`).
- `reset` asserted during HI → next cycle IDLE, `busy`=0, q=0000, f_out=00, no `done` pulse.
- INC16, a=FFFF, f_in=A5:
  - With macro defined → q=0000, f_out=A5.
  - With macro undefined → `busy` never rises.
